// File: rtl/control_unit_if.sv
// Control-unit <-> DataPath bundle: instruction/condition/pause inputs toward
// the sequencer and every datapath strobe it drives back.
interface control_unit_if;
  logic [31:0] IR;
  logic        con_out;
  logic        Stop;
  logic        Run;
  logic        PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out, R_out;
  logic        PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable;
  logic        Read, RAM_write_enable, out_port_enable, con_in, Gra, Grb, Grc, R_in;
  logic [4:0]  opcode;

  // sequencer side
  modport master (
    input  IR, con_out, Stop,
    output Run, PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out,
           R_out, PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable,
           HI_enable, LO_enable, Read, RAM_write_enable, out_port_enable, con_in, Gra, Grb, Grc,
           R_in, opcode
  );

  // datapath side
  modport slave (
    output IR, con_out, Stop,
    input  Run, PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out, BA_out,
           R_out, PC_enable, IncPC, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable,
           HI_enable, LO_enable, Read, RAM_write_enable, out_port_enable, con_in, Gra, Grb, Grc,
           R_in, opcode
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, execute T3-T7 per IR[31:27].
// Strobes are a Moore decode of the registered step plus the opcode, so a
// freshly loaded IR is seen in T3 without an extra cycle.
module control_unit #(
  parameter int         MEM_WAIT = 0,
  parameter logic [4:0] ALU_ADD  = 5'b00011
) (
  input  logic          Clock,
  input  logic          clr,
  control_unit_if.master cu
);
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, WAIT, PAUSE, HALT} state_e;

  // wait counter holds remaining extra cycles minus one
  localparam int            CW      = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LD = (MEM_WAIT > 0) ? CW'(MEM_WAIT - 1) : '0;

  state_e        state_q, state_d, end_st;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ret_q, ret_d;   // 1: WAIT returns to T7 (ld), 0: to T2 (fetch)
  logic [4:0]    op;
  logic [2:0]    last_step;
  logic          is_r, is_imm, is_md, is_nn, is_ld, is_ldi, is_st, is_br, is_jal, is_jr;
  logic          is_in, is_out, is_mflo, is_mfhi, is_halt;
  logic          unused_ir;

  assign op        = cu.IR[31:27];
  assign unused_ir = ^cu.IR[26:0];
  assign is_r      = op inside {[5'd3:5'd11]};
  assign is_imm    = op inside {[5'd12:5'd14]};
  assign is_md     = op inside {5'd15, 5'd16};
  assign is_nn     = op inside {5'd17, 5'd18};
  assign is_ld     = (op == 5'd0);
  assign is_ldi    = (op == 5'd1);
  assign is_st     = (op == 5'd2);
  assign is_br     = (op == 5'd19);
  assign is_jal    = (op == 5'd20);
  assign is_jr     = (op == 5'd21);
  assign is_in     = (op == 5'd22);
  assign is_out    = (op == 5'd23);
  assign is_mflo   = (op == 5'd24);
  assign is_mfhi   = (op == 5'd25);
  assign is_halt   = (op == 5'd27);

  // final execute step of the current instruction (2 = no execute phase)
  always_comb begin
    last_step = 3'd2;
    if (is_jr || is_in || is_out || is_mflo || is_mfhi) last_step = 3'd3;
    else if (is_nn || is_jal)                           last_step = 3'd4;
    else if (is_r || is_imm || is_ldi)                  last_step = 3'd5;
    else if (is_md || is_br)                            last_step = 3'd6;
    else if (is_ld || is_st)                            last_step = 3'd7;
  end

  // step sequencing, memory-wait hold and pause at instruction boundaries
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    end_st  = cu.Stop ? PAUSE : T0;
    unique case (state_q)
      RESET: state_d = T0;
      T0:    state_d = T1;
      T1: begin
        state_d = T2;
        if (MEM_WAIT > 0) begin state_d = WAIT; cnt_d = WAIT_LD; ret_d = 1'b0; end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ret_q ? T7 : T2;
        else             cnt_d   = cnt_q - 1'b1;
      end
      T2: begin
        if (is_halt)                state_d = HALT;
        else if (last_step == 3'd2) state_d = end_st;
        else                        state_d = T3;
      end
      T3: state_d = (last_step == 3'd3) ? end_st : T4;
      T4: state_d = (last_step == 3'd4) ? end_st : T5;
      T5: state_d = (last_step == 3'd5) ? end_st : T6;
      T6: begin
        if (last_step == 3'd6) state_d = end_st;
        else begin
          state_d = T7;
          if (is_ld && MEM_WAIT > 0) begin state_d = WAIT; cnt_d = WAIT_LD; ret_d = 1'b1; end
        end
      end
      T7:      state_d = end_st;
      PAUSE:   state_d = cu.Stop ? PAUSE : T0;
      HALT:    state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  // state registers; clr overrides everything
  always_ff @(posedge Clock) begin
    if (clr) begin
      state_q <= RESET;
      cnt_q   <= '0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  // strobe decode of the current step and opcode
  always_comb begin
    cu.Run = 1'b0;
    cu.PC_out = 1'b0; cu.ZLow_out = 1'b0; cu.ZHigh_out = 1'b0; cu.HI_out = 1'b0; cu.LO_out = 1'b0;
    cu.C_out = 1'b0; cu.MDR_out = 1'b0; cu.in_port_out = 1'b0; cu.BA_out = 1'b0; cu.R_out = 1'b0;
    cu.PC_enable = 1'b0; cu.IncPC = 1'b0; cu.MAR_enable = 1'b0; cu.MDR_enable = 1'b0;
    cu.IR_enable = 1'b0; cu.Y_enable = 1'b0; cu.Z_enable = 1'b0; cu.HI_enable = 1'b0;
    cu.LO_enable = 1'b0; cu.Read = 1'b0; cu.RAM_write_enable = 1'b0; cu.out_port_enable = 1'b0;
    cu.con_in = 1'b0; cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0; cu.R_in = 1'b0;
    cu.opcode = 5'd0;
    if (state_q inside {T0, T1, T2, T3, T4, T5, T6, T7, WAIT}) cu.Run = 1'b1;
    unique case (state_q)
      T0: begin cu.PC_out = 1'b1; cu.MAR_enable = 1'b1; cu.IncPC = 1'b1; cu.PC_enable = 1'b1; end
      T1, WAIT: begin cu.Read = 1'b1; cu.MDR_enable = 1'b1; end
      T2: begin cu.MDR_out = 1'b1; cu.IR_enable = 1'b1; end
      T3: begin
        if (is_r || is_imm) begin cu.Grb = 1'b1; cu.R_out = 1'b1; cu.Y_enable = 1'b1; end
        if (is_md)          begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.Y_enable = 1'b1; end
        if (is_nn)          begin cu.Grb = 1'b1; cu.R_out = 1'b1; cu.Z_enable = 1'b1; cu.opcode = op; end
        if (is_ld || is_ldi || is_st) begin cu.Grb = 1'b1; cu.BA_out = 1'b1; cu.Y_enable = 1'b1; end
        if (is_br)   begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.con_in = 1'b1; end
        if (is_jr)   begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.PC_enable = 1'b1; end
        if (is_jal)  begin cu.PC_out = 1'b1; cu.Grb = 1'b1; cu.R_in = 1'b1; end
        if (is_in)   begin cu.in_port_out = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
        if (is_out)  begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.out_port_enable = 1'b1; end
        if (is_mflo) begin cu.LO_out = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
        if (is_mfhi) begin cu.HI_out = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
      end
      T4: begin
        if (is_r)   begin cu.Grc = 1'b1; cu.R_out = 1'b1; cu.Z_enable = 1'b1; cu.opcode = op; end
        if (is_imm) begin cu.C_out = 1'b1; cu.Z_enable = 1'b1; cu.opcode = op; end
        if (is_md)  begin cu.Grb = 1'b1; cu.R_out = 1'b1; cu.Z_enable = 1'b1; cu.opcode = op; end
        if (is_nn)  begin cu.ZLow_out = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
        if (is_ld || is_ldi || is_st) begin cu.C_out = 1'b1; cu.Z_enable = 1'b1; cu.opcode = ALU_ADD; end
        if (is_br)  begin cu.PC_out = 1'b1; cu.Y_enable = 1'b1; end
        if (is_jal) begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.PC_enable = 1'b1; end
      end
      T5: begin
        if (is_r || is_imm || is_ldi) begin cu.ZLow_out = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
        if (is_md)          begin cu.ZLow_out = 1'b1; cu.LO_enable = 1'b1; end
        if (is_ld || is_st) begin cu.ZLow_out = 1'b1; cu.MAR_enable = 1'b1; end
        if (is_br)          begin cu.C_out = 1'b1; cu.Z_enable = 1'b1; cu.opcode = op; end
      end
      T6: begin
        if (is_md) begin cu.ZHigh_out = 1'b1; cu.HI_enable = 1'b1; end
        if (is_ld) begin cu.Read = 1'b1; cu.MDR_enable = 1'b1; end
        if (is_st) begin cu.Gra = 1'b1; cu.R_out = 1'b1; cu.MDR_enable = 1'b1; end
        if (is_br) begin cu.ZLow_out = 1'b1; cu.PC_enable = cu.con_out; end
      end
      T7: begin
        if (is_ld) begin cu.MDR_out = 1'b1; cu.Gra = 1'b1; cu.R_in = 1'b1; end
        if (is_st) cu.RAM_write_enable = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: per-cycle expected strobe vectors are queued when an
// instruction is launched and popped/compared on each falling edge.
module tb_control_unit;
  logic gclk = 1'b0;
  logic clr0, clr2;
  always #5 gclk = ~gclk;

  control_unit_if i0();
  control_unit_if i2();
  control_unit #(.MEM_WAIT(0)) dut0 (.Clock(gclk), .clr(clr0), .cu(i0));
  control_unit #(.MEM_WAIT(2)) dut2 (.Clock(gclk), .clr(clr2), .cu(i2));

  // strobe bit positions in the packed observation
  localparam logic [26:0] PCO  = 27'd1 << 0,  ZLO  = 27'd1 << 1,  ZHO  = 27'd1 << 2;
  localparam logic [26:0] COUT = 27'd1 << 5,  MDRO = 27'd1 << 6,  BAO  = 27'd1 << 8;
  localparam logic [26:0] ROUT = 27'd1 << 9,  PCEN = 27'd1 << 10, INC  = 27'd1 << 11;
  localparam logic [26:0] MARE = 27'd1 << 12, MDRE = 27'd1 << 13, IRE  = 27'd1 << 14;
  localparam logic [26:0] YEN  = 27'd1 << 15, ZEN  = 27'd1 << 16, RD   = 27'd1 << 19;
  localparam logic [26:0] RAMW = 27'd1 << 20, CONI = 27'd1 << 22, GRA  = 27'd1 << 23;
  localparam logic [26:0] GRB  = 27'd1 << 24, GRC  = 27'd1 << 25, RIN  = 27'd1 << 26;
  localparam logic [26:0] F0 = PCO | MARE | INC | PCEN, F1 = RD | MDRE, F2 = MDRO | IRE, Z = 27'd0;

  localparam logic [31:0] IR_ADD = 32'h18A2_0000;
  localparam logic [31:0] IR_BR  = {5'b10011, 27'd0};
  localparam logic [31:0] IR_LD  = {5'b00000, 27'h123};
  localparam logic [31:0] IR_ST  = {5'b00010, 27'h40};
  localparam logic [31:0] IR_HLT = {5'b11011, 27'd0};
  localparam logic [31:0] IR_NOP = {5'b11010, 27'd0};

  typedef struct { logic [32:0] v; bit sel; string tag; } exp_t;
  exp_t q[$];
  exp_t m_e;
  int   n_chk = 0, n_err = 0;

  logic [32:0] obs0, obs2;
  assign obs0 = {i0.Run, i0.opcode, i0.R_in, i0.Grc, i0.Grb, i0.Gra, i0.con_in, i0.out_port_enable,
                 i0.RAM_write_enable, i0.Read, i0.LO_enable, i0.HI_enable, i0.Z_enable, i0.Y_enable,
                 i0.IR_enable, i0.MDR_enable, i0.MAR_enable, i0.IncPC, i0.PC_enable, i0.R_out,
                 i0.BA_out, i0.in_port_out, i0.MDR_out, i0.C_out, i0.LO_out, i0.HI_out,
                 i0.ZHigh_out, i0.ZLow_out, i0.PC_out};
  assign obs2 = {i2.Run, i2.opcode, i2.R_in, i2.Grc, i2.Grb, i2.Gra, i2.con_in, i2.out_port_enable,
                 i2.RAM_write_enable, i2.Read, i2.LO_enable, i2.HI_enable, i2.Z_enable, i2.Y_enable,
                 i2.IR_enable, i2.MDR_enable, i2.MAR_enable, i2.IncPC, i2.PC_enable, i2.R_out,
                 i2.BA_out, i2.in_port_out, i2.MDR_out, i2.C_out, i2.LO_out, i2.HI_out,
                 i2.ZHigh_out, i2.ZLow_out, i2.PC_out};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic ex(input string tag, input bit sel, input logic [26:0] s,
                    input logic [4:0] opc = 5'd0, input logic run = 1'b1);
    exp_t e;
    e.v = {run, opc, s}; e.sel = sel; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  // one-cycle clr; on return the DUT sits in RESET for the current cycle
  task automatic restart(input bit sel);
    if (sel) clr2 = 1'b1; else clr0 = 1'b1;
    tick(1);
    if (sel) clr2 = 1'b0; else clr0 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    chk("drain", q.size(), 0);
  endtask

  task automatic ex_fetch(input string tag, input bit sel);
    ex({tag, "_rst"}, sel, Z, 5'd0, 1'b0);
    ex({tag, "_t0"}, sel, F0);
    ex({tag, "_t1"}, sel, F1);
    ex({tag, "_t2"}, sel, F2);
  endtask

  always @(negedge gclk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk(m_e.tag, m_e.sel ? obs2 : obs0, m_e.v);
    end
  end

  initial begin
    clr0 = 1'b1; clr2 = 1'b1;
    i0.IR = '0; i0.con_out = 1'b0; i0.Stop = 1'b0;
    i2.IR = '0; i2.con_out = 1'b0; i2.Stop = 1'b0;
    tick(3);

    // add: 6 cycles, back at T0 on the 7th
    i0.IR = IR_ADD;
    restart(0);
    ex_fetch("add", 0);
    ex("add_t3", 0, GRB | ROUT | YEN);
    ex("add_t4", 0, GRC | ROUT | ZEN, 5'b00011);
    ex("add_t5", 0, ZLO | GRA | RIN);
    ex("add_t0b", 0, F0);
    drain();

    // br taken then not taken
    for (int c = 1; c >= 0; c--) begin
      i0.IR = IR_BR; i0.con_out = c[0];
      restart(0);
      ex_fetch("br", 0);
      ex("br_t3", 0, GRA | ROUT | CONI);
      ex("br_t4", 0, PCO | YEN);
      ex("br_t5", 0, COUT | ZEN, 5'b10011);
      ex(c[0] ? "br_t6_taken" : "br_t6_not", 0, c[0] ? (ZLO | PCEN) : ZLO);
      ex("br_t0b", 0, F0);
      drain();
    end

    // nop: 3 cycles
    i0.IR = IR_NOP;
    restart(0);
    ex_fetch("nop", 0);
    ex("nop_t0b", 0, F0);
    drain();

    // ld without memory wait: 8 cycles
    i0.IR = IR_LD;
    restart(0);
    ex_fetch("ld0", 0);
    ex("ld0_t3", 0, GRB | BAO | YEN);
    ex("ld0_t4", 0, COUT | ZEN, 5'b00011);
    ex("ld0_t5", 0, ZLO | MARE);
    ex("ld0_t6", 0, RD | MDRE);
    ex("ld0_t7", 0, MDRO | GRA | RIN);
    ex("ld0_t0b", 0, F0);
    drain();

    // halt: parked for 20 cycles, then clr restarts fetch
    i0.IR = IR_HLT;
    restart(0);
    ex_fetch("hlt", 0);
    for (int k = 0; k < 20; k++) ex("hlt_park", 0, Z, 5'd0, 1'b0);
    drain();
    restart(0);
    ex("hlt_rst", 0, Z, 5'd0, 1'b0);
    ex("hlt_t0", 0, F0);
    drain();

    // Stop raised in add T4 takes effect only at the boundary
    i0.IR = IR_ADD;
    restart(0);
    ex_fetch("stp", 0);
    ex("stp_t3", 0, GRB | ROUT | YEN);
    ex("stp_t4", 0, GRC | ROUT | ZEN, 5'b00011);
    ex("stp_t5", 0, ZLO | GRA | RIN);
    ex("stp_pause", 0, Z, 5'd0, 1'b0);
    ex("stp_pause2", 0, Z, 5'd0, 1'b0);
    ex("stp_t0", 0, F0);
    tick(5);
    i0.Stop = 1'b1;
    tick(3);
    i0.Stop = 1'b0;
    drain();

    // clr during st T6: no RAM write ever appears
    i0.IR = IR_ST;
    restart(0);
    ex_fetch("st", 0);
    ex("st_t3", 0, GRB | BAO | YEN);
    ex("st_t4", 0, COUT | ZEN, 5'b00011);
    ex("st_t5", 0, ZLO | MARE);
    ex("st_t6", 0, GRA | ROUT | MDRE);
    ex("st_clr", 0, Z, 5'd0, 1'b0);
    ex("st_t0", 0, F0);
    tick(7);
    clr0 = 1'b1;
    tick(1);
    clr0 = 1'b0;
    drain();

    // ld with MEM_WAIT=2: both reads held 3 cycles, 12 cycles total
    clr0 = 1'b1;
    i2.IR = IR_LD;
    restart(1);
    ex("ldw_rst", 1, Z, 5'd0, 1'b0);
    ex("ldw_t0", 1, F0);
    for (int k = 0; k < 3; k++) ex("ldw_t1", 1, F1);
    ex("ldw_t2", 1, F2);
    ex("ldw_t3", 1, GRB | BAO | YEN);
    ex("ldw_t4", 1, COUT | ZEN, 5'b00011);
    ex("ldw_t5", 1, ZLO | MARE);
    for (int k = 0; k < 3; k++) ex("ldw_t6", 1, RD | MDRE);
    ex("ldw_t7", 1, MDRO | GRA | RIN);
    ex("ldw_t0b", 1, F0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
